// File: rtl/pu_msp430_input_filter.sv
// Glitch filter and edge detector placed after the two-flop synchronizer.
// Define PU_MSP430_INPUT_FILTER_EN to build the counting filter; otherwise the input passes through with one cycle of latency.
module pu_msp430_input_filter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_data_in,
  input  logic [CNT_W-1:0] i_filt_len,
  input  logic             i_edge_sel,
  input  logic             i_irq_en,
  input  logic             i_irq_clr,
  output logic             o_data_out,
  output logic             o_rise_pulse,
  output logic             o_fall_pulse,
  output logic             o_irq_flag
);

  logic r_data_out;
  logic r_rise_pulse;
  logic r_fall_pulse;
  logic r_irq_flag;

  logic w_diff;
  logic w_accept;
  logic w_rise;
  logic w_fall;
  logic w_irq_set;

  assign w_diff = i_data_in ^ r_data_out;

`ifdef PU_MSP430_INPUT_FILTER_EN
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_FILTER = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The >= compare lets a lowered filter length take effect on the next differing sample.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      ST_STABLE: begin
        w_cnt_next = '0;
        if (w_diff) begin
          if (i_filt_len == '0) begin
            w_accept = 1'b1;
          end else begin
            w_state_next = ST_FILTER;
            w_cnt_next   = CNT_W'(1);
          end
        end
      end
      ST_FILTER: begin
        if (!w_diff) begin
          w_state_next = ST_STABLE;
          w_cnt_next   = '0;
        end else if (r_cnt >= i_filt_len) begin
          w_accept     = 1'b1;
          w_state_next = ST_STABLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = ST_STABLE;
        w_cnt_next   = '0;
      end
    endcase
  end
`else
  logic w_unused_filt_len;

  assign w_unused_filt_len = ^i_filt_len;
  assign w_accept          = w_diff;
`endif

  // An accepted change always moves data_out to data_in, so the new level picks the pulse.
  assign w_rise    = w_accept & i_data_in;
  assign w_fall    = w_accept & ~i_data_in;
  assign w_irq_set = i_irq_en & ((w_rise & ~i_edge_sel) | (w_fall & i_edge_sel));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= 1'b0;
      r_rise_pulse <= 1'b0;
      r_fall_pulse <= 1'b0;
      r_irq_flag   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data_out <= i_data_in;
      end
      r_rise_pulse <= w_rise;
      r_fall_pulse <= w_fall;
      if (w_irq_set) begin
        r_irq_flag <= 1'b1;
      end else if (i_irq_clr) begin
        r_irq_flag <= 1'b0;
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_rise_pulse = r_rise_pulse;
  assign o_fall_pulse = r_fall_pulse;
  assign o_irq_flag   = r_irq_flag;

endmodule

// File: tb/tb_pu_msp430_input_filter.sv
// Directed self-checking bench for pu_msp430_input_filter; expectations follow the build (filtered or pass-through).
module tb_pu_msp430_input_filter;

`ifdef PU_MSP430_INPUT_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       data_in;
  logic [7:0] filt_len;
  logic       edge_sel;
  logic       irq_en;
  logic       irq_clr;
  logic       data_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       irq_flag;

  int n_checks;
  int n_fail;

  pu_msp430_input_filter #(.CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data_in    (data_in),
    .i_filt_len   (filt_len),
    .i_edge_sel   (edge_sel),
    .i_irq_en     (irq_en),
    .i_irq_clr    (irq_clr),
    .o_data_out   (data_out),
    .o_rise_pulse (rise_pulse),
    .o_fall_pulse (fall_pulse),
    .o_irq_flag   (irq_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input bit d, input bit r, input bit f, input bit q);
    check_value({tag, "/data_out"}, {7'd0, data_out}, {7'd0, d});
    check_value({tag, "/rise"}, {7'd0, rise_pulse}, {7'd0, r});
    check_value({tag, "/fall"}, {7'd0, fall_pulse}, {7'd0, f});
    check_value({tag, "/irq"}, {7'd0, irq_flag}, {7'd0, q});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    bit prev;
    bit exp_d;
    bit pat [10] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0};

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    data_in  = 1'b1;
    filt_len = 8'd0;
    edge_sel = 1'b0;
    irq_en   = 1'b0;
    irq_clr  = 1'b0;

    // Reset held with input high, then release with filt_len = 0
    repeat (3) tick();
    expect_outs("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    expect_outs("rel_e1", 1, 1, 0, 0);
    tick();
    expect_outs("rel_e2", 1, 0, 0, 0);
    $display("txn reset_release done");

    // Rising change with filt_len = 3
    data_in = 1'b0;
    tick();
    expect_outs("fall_n0", 0, 0, 1, 0);
    filt_len = 8'd3;
    edge_sel = 1'b0;
    irq_en   = 1'b1;
    tick();
    data_in = 1'b1;
    lat = FILT_EN ? 4 : 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_outs($sformatf("rise3_e%0d", i), (i >= lat), (i == lat), 0, (i >= lat));
    end
    tick();
    expect_outs("rise3_after", 1, 0, 0, 1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    expect_outs("irq_clr", 1, 0, 0, 0);
    $display("txn rise_filt3 done");

    // Return low, then 3-sample and 2-sample glitches
    data_in = 1'b0;
    repeat (5) tick();
    expect_outs("settle_low", 0, 0, 0, 0);
    prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_in = pat[i];
      tick();
      exp_d = FILT_EN ? 1'b0 : pat[i];
      expect_outs($sformatf("glitch_s%0d", i), exp_d,
                  FILT_EN ? 1'b0 : (pat[i] & ~prev),
                  FILT_EN ? 1'b0 : (~pat[i] & prev),
                  FILT_EN ? 1'b0 : 1'b1);
      prev = pat[i];
    end
    $display("txn glitch_reject done");

    // Falling-edge IRQ select with filt_len = 1
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_value("pre_edge_irq", {7'd0, irq_flag}, 8'd0);
    filt_len = 8'd1;
    edge_sel = 1'b1;
    lat      = FILT_EN ? 2 : 1;
    data_in  = 1'b1;
    repeat (lat) tick();
    expect_outs("sel1_rise", 1, 1, 0, 0);
    data_in = 1'b0;
    repeat (lat) tick();
    expect_outs("sel1_fall", 0, 0, 1, 1);
    irq_en = 1'b0;
    tick();
    expect_outs("irq_en_low_hold", 0, 0, 0, 1);
    irq_en  = 1'b1;
    data_in = 1'b1;
    repeat (lat + 1) tick();
    expect_outs("sel1_rise2", 1, 0, 0, 1);
    data_in = 1'b0;
    repeat (lat - 1) tick();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    expect_outs("set_beats_clr", 0, 0, 1, 1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    expect_outs("clr_only", 0, 0, 0, 0);
    $display("txn edge_sel_falling done");

    // filt_len lowered from 10 to 2 after four differing samples
    edge_sel = 1'b0;
    filt_len = 8'd10;
    data_in  = 1'b1;
    lat      = FILT_EN ? 5 : 1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) filt_len = 8'd2;
      tick();
      expect_outs($sformatf("lower_e%0d", i), (i >= lat), (i == lat), 0, (i >= lat));
    end
    $display("txn filt_len_lowered done");

    // Asynchronous reset in the middle of a filter count
    filt_len = 8'd0;
    data_in  = 1'b0;
    tick();
    expect_outs("pre_rst_fall", 0, 0, 1, 1);
    filt_len = 8'd3;
    data_in  = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    expect_outs("async_rst", 0, 0, 0, 0);
    data_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_outs($sformatf("post_rst_e%0d", i), 0, 0, 0, 0);
    end
    $display("txn reset_mid_filter done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
